// File: rtl/division_seq.sv
// division_seq: multi-cycle restoring divider with signed/unsigned modes and a fixed latency.
// Ports:
//   clk, rst          - clock; asynchronous active-high reset
//   i_start           - request pulse, accepted only in IDLE or DONE
//   i_signed          - 1 = two's-complement operands, 0 = unsigned
//   i_dividend        - dividend (WIDTH bits)
//   i_divisor         - divisor (WIDTH bits)
//   o_busy            - high while iterating (CALC) or sign-fixing (FIX)
//   o_done            - one-cycle pulse while the results are fresh
//   o_quotient        - quotient, held until the next completion
//   o_remainder       - remainder, held until the next completion
//   o_div_zero        - last completed division had a zero divisor
//   o_overflow        - last completed division was signed MIN / -1
module division_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_zero,
    output logic             o_overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;
    logic             overflow_q, overflow_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic             fits;

    assign accept = i_start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? CALC : IDLE;
            CALC:    state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
            FIX:     state_d = DONE;
            default: state_d = accept ? CALC : IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state_q == CALC) || (state_q == FIX);
        o_done      = (state_q == DONE);
        o_quotient  = quotient_q;
        o_remainder = remainder_q;
        o_div_zero  = div_zero_q;
        o_overflow  = overflow_q;
    end

    // Magnitudes stay WIDTH-bit unsigned so that -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    always_comb begin
        a_neg   = i_signed && i_dividend[WIDTH-1];
        b_neg   = i_signed && i_divisor[WIDTH-1];
        mag_a   = a_neg ? -i_dividend : i_dividend;
        mag_b   = b_neg ? -i_divisor : i_divisor;
        // Partial remainder is below the divisor, so the shifted value needs one extra bit;
        // when it fits, the difference again fits in WIDTH bits.
        shifted = {rem_q, quo_q[WIDTH-1]};
        fits    = shifted >= {1'b0, dvs_q};
    end

    always_comb begin
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;
        if (accept) begin
            cnt_d     = '0;
            quo_d     = mag_a;
            rem_d     = '0;
            dvs_d     = mag_b;
            dz_d      = (i_divisor == '0);
            // A zero divisor must keep the all-ones quotient, so it is never negated.
            neg_quo_d = (a_neg != b_neg) && (i_divisor != '0);
            neg_rem_d = a_neg;
            ovf_d     = i_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_divisor);
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + CW'(1);
            quo_d = {quo_q[WIDTH-2:0], fits};
            rem_d = fits ? shifted[WIDTH-1:0] - dvs_q : shifted[WIDTH-1:0];
        end else if (state_q == FIX) begin
            quotient_d  = neg_quo_q ? -quo_q : quo_q;
            remainder_d = neg_rem_q ? -rem_q : rem_q;
            div_zero_d  = dz_q;
            overflow_d  = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_division_seq.sv
// tb_division_seq: vector table, hand-written multi-cycle sequences and random checks for division_seq.
module tb_division_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_start = 1'b0;
    logic         i_signed = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_busy, o_done, o_div_zero, o_overflow;
    logic [W-1:0] o_quotient, o_remainder;

    int n_chk = 0;
    int n_fail = 0;

    division_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_signed(i_signed),
        .i_dividend(i_dividend), .i_divisor(i_divisor), .o_busy(o_busy), .o_done(o_done),
        .o_quotient(o_quotient), .o_remainder(o_remainder), .o_div_zero(o_div_zero),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference from the arithmetic rules: truncating division, remainder follows the dividend.
    function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -(2 ** (W - 1)) && sb == -1) begin
                q  = a;
                r  = '0;
                ov = 1'b1;
            end else begin
                q = W'(sa / sb);
                r = W'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Starts one division and returns the number of edges from the accepting edge (inclusive)
    // to the edge entering DONE; operands are scrambled right after acceptance.
    task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic busy_mid);
        @(negedge clk);
        i_start    = 1'b1;
        i_signed   = sgn;
        i_dividend = a;
        i_divisor  = b;
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_signed   = 1'($urandom);
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
        lat = 1;
        busy_mid = o_busy;
        while (!o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic sgn, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic dz, ov, bm;
        int lat;
        model(sgn, a, b, q, r, dz, ov);
        do_div(sgn, a, b, lat, bm);
        chk({tag, " latency"}, lat, 10);
        chk({tag, " busy"}, bm, 1);
        chk({tag, " quotient"}, o_quotient, q);
        chk({tag, " remainder"}, o_remainder, r);
        chk({tag, " div_zero"}, o_div_zero, dz);
        chk({tag, " overflow"}, o_overflow, ov);
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] q, r;
        logic dz, ov, bm, seen;
        int lat;
        vecs = '{
            '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0},
            '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, 1'b0},
            '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0},
            '{1'b0, 8'd55,  8'd0,   8'hFF,  8'd55,  1'b1, 1'b0},
            '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, 1'b1},
            '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, 1'b0},
            '{1'b1, 8'hF9,  8'h00,  8'hFF,  8'hF9,  1'b1, 1'b0},
            '{1'b0, 8'd200, 8'd3,   8'd66,  8'd2,   1'b0, 1'b0},
            '{1'b1, 8'h80,  8'h01,  8'h80,  8'h00,  1'b0, 1'b0},
            '{1'b0, 8'hFF,  8'hFF,  8'h01,  8'h00,  1'b0, 1'b0}
        };

        #1;
        chk("reset busy", o_busy, 0);
        chk("reset done", o_done, 0);
        chk("reset quotient", o_quotient, 0);
        chk("reset remainder", o_remainder, 0);
        chk("reset div_zero", o_div_zero, 0);
        chk("reset overflow", o_overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bm);
            chk($sformatf("vec%0d latency", i), lat, 10);
            chk($sformatf("vec%0d busy", i), bm, 1);
            chk($sformatf("vec%0d quotient", i), o_quotient, vecs[i].q);
            chk($sformatf("vec%0d remainder", i), o_remainder, vecs[i].r);
            chk($sformatf("vec%0d div_zero", i), o_div_zero, vecs[i].dz);
            chk($sformatf("vec%0d overflow", i), o_overflow, vecs[i].ov);
        end

        // o_done is a single-cycle pulse when no new start arrives.
        @(posedge clk);
        #1;
        chk("done single pulse", o_done, 0);
        chk("idle not busy", o_busy, 0);

        // Start held high throughout: ignored while busy, then back-to-back from DONE.
        @(negedge clk);
        i_start    = 1'b1;
        i_signed   = 1'b0;
        i_dividend = 8'd100;
        i_divisor  = 8'd7;
        @(posedge clk);
        #1;
        i_dividend = 8'd200;
        i_divisor  = 8'd3;
        lat = 1;
        while (!o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held start latency", lat, 10);
        chk("held start quotient", o_quotient, 14);
        chk("held start remainder", o_remainder, 2);
        lat = 0;
        @(posedge clk);
        #1;
        lat++;
        while (!o_done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        i_start = 1'b0;
        chk("back-to-back latency", lat, 10);
        chk("back-to-back quotient", o_quotient, 66);
        chk("back-to-back remainder", o_remainder, 2);
        @(posedge clk);
        #1;
        chk("back-to-back done drop", o_done, 0);

        // Reset in the middle of CALC abandons the division.
        @(negedge clk);
        i_start    = 1'b1;
        i_dividend = 8'd50;
        i_divisor  = 8'd5;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset busy", o_busy, 0);
        chk("midreset done", o_done, 0);
        chk("midreset quotient", o_quotient, 0);
        chk("midreset remainder", o_remainder, 0);
        chk("midreset div_zero", o_div_zero, 0);
        chk("midreset overflow", o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | o_done;
        end
        chk("midreset no done", seen, 0);
        check_result("post-reset 200/3", 1'b0, 8'd200, 8'd3);

        // Random operands, with zero divisors and MIN/-1 forced in now and then.
        for (int i = 0; i < 150; i++) begin
            logic s;
            logic [W-1:0] a, b;
            s = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 9) == 0) b = '0;
            if ($urandom_range(0, 19) == 0) begin
                a = 8'h80;
                b = 8'hFF;
            end
            check_result($sformatf("rand%0d %0b %0h/%0h", i, s, a, b), s, a, b);
        end

        model(1'b1, 8'h81, 8'h07, q, r, dz, ov);
        do_div(1'b1, 8'h81, 8'h07, lat, bm);
        chk("final quotient", o_quotient, q);
        chk("final remainder", o_remainder, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
